hd_ngram_encoder: RTL and testbench

Parametrised streaming HD encoder that turns a sequence of item hypervectors into one bundled N-gram prototype.
- Each accepted item is bound (XOR) with rotated copies of the previous N-1 items to form an N-gram.
- N-grams are accumulated into per-bit saturating up/down counters and thresholded into a DIM-bit result when the sequence ends.
- Sits between the item-memory read path and the associative-memory write/search path. Valid/ready on both sides.

---
 rtl/hd_ngram_encoder_if.sv | 31 +++
 rtl/hd_ngram_encoder.sv | 124 ++++++++++++
 tb/tb_hd_ngram_encoder.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hd_ngram_encoder_if.sv
// Item-stream and result-stream handshake bundle for the N-gram encoder.
// The master side feeds items and consumes results; the slave side is the encoder.
interface hd_ngram_encoder_if #(
    parameter int DIM         = 512,
    parameter int NGRAM_MAX   = 4,
    parameter int COUNT_WIDTH = 16
);
    localparam int CFG_W = $clog2(NGRAM_MAX + 1);

    logic [CFG_W-1:0]       cfg_ngram_len_i;
    logic                   item_valid_i;
    logic                   item_ready_o;
    logic [DIM-1:0]         item_i;
    logic                   item_last_i;
    logic                   result_valid_o;
    logic                   result_ready_i;
    logic [DIM-1:0]         result_o;
    logic [COUNT_WIDTH-1:0] result_count_o;
    logic                   result_empty_o;
    logic                   busy_o;

    modport master (
        output cfg_ngram_len_i, item_valid_i, item_i, item_last_i, result_ready_i,
        input  item_ready_o, result_valid_o, result_o, result_count_o, result_empty_o, busy_o
    );

    modport slave (
        input  cfg_ngram_len_i, item_valid_i, item_i, item_last_i, result_ready_i,
        output item_ready_o, result_valid_o, result_o, result_count_o, result_empty_o, busy_o
    );
endinterface

// File: rtl/hd_ngram_encoder.sv
// Streaming HD N-gram encoder: binds each item with rotated history items, bundles
// the N-grams into saturating per-bit counters and thresholds them at sequence end.
module hd_ngram_encoder #(
    parameter int DIM         = 512,
    parameter int NGRAM_MAX   = 4,
    parameter int CNTR_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    hd_ngram_encoder_if.slave  bus
);
    localparam int CFG_W      = $clog2(NGRAM_MAX + 1);
    localparam int HIST_DEPTH = (NGRAM_MAX > 1) ? NGRAM_MAX - 1 : 1;
    localparam logic signed [CNTR_WIDTH-1:0] CNT_MAX = {1'b0, {(CNTR_WIDTH-1){1'b1}}};
    localparam logic signed [CNTR_WIDTH-1:0] CNT_MIN = -CNT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;

    state_t                        r_state;
    logic [CFG_W-1:0]              r_n;
    logic [CFG_W-1:0]              r_fill;
    logic [DIM-1:0]                r_hist [HIST_DEPTH];
    logic signed [CNTR_WIDTH-1:0]  r_cnt [DIM];
    logic [COUNT_WIDTH-1:0]        r_count;
    logic [DIM-1:0]                r_result;
    logic                          r_empty;

    logic [CFG_W-1:0]              w_cfgN;
    logic [CFG_W-1:0]              w_n;
    logic [CFG_W-1:0]              w_fillNext;
    logic                          w_accept;
    logic                          w_bundle;
    logic                          w_clear;
    logic [DIM-1:0]                w_ngram;
    logic signed [CNTR_WIDTH-1:0]  w_cntNext [DIM];
    logic [COUNT_WIDTH-1:0]        w_countNext;
    logic [DIM-1:0]                w_resultNext;

    function automatic logic [DIM-1:0] rotl(input logic [DIM-1:0] v, input int amt);
        logic [DIM-1:0] r;
        int a;
        a = amt % DIM;
        for (int i = 0; i < DIM; i++) begin
            r[i] = v[(i - a + DIM) % DIM];
        end
        return r;
    endfunction

    always_comb begin
        w_cfgN = bus.cfg_ngram_len_i;
        if (bus.cfg_ngram_len_i == '0) begin
            w_cfgN = CFG_W'(1);
        end else if (bus.cfg_ngram_len_i > CFG_W'(NGRAM_MAX)) begin
            w_cfgN = CFG_W'(NGRAM_MAX);
        end
    end

    // N is only taken from the config port on the first item of a sequence.
    assign w_n        = (r_state == S_IDLE) ? w_cfgN : r_n;
    assign w_fillNext = (r_fill == CFG_W'(NGRAM_MAX)) ? r_fill : r_fill + CFG_W'(1);
    assign w_accept   = bus.item_valid_i && (r_state != S_OUT);
    assign w_bundle   = w_accept && (w_fillNext >= w_n);
    assign w_clear    = rst_i || ((r_state == S_OUT) && bus.result_ready_i);

    always_comb begin
        w_ngram = bus.item_i;
        for (int k = 1; k < NGRAM_MAX; k++) begin
            if (k < int'(w_n)) begin
                w_ngram = w_ngram ^ rotl(r_hist[k-1], k);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            w_cntNext[i] = r_cnt[i];
            if (w_bundle) begin
                if (w_ngram[i]) begin
                    if (r_cnt[i] != CNT_MAX) w_cntNext[i] = r_cnt[i] + CNTR_WIDTH'(1);
                end else begin
                    if (r_cnt[i] != CNT_MIN) w_cntNext[i] = r_cnt[i] - CNTR_WIDTH'(1);
                end
            end
            w_resultNext[i] = !w_cntNext[i][CNTR_WIDTH-1] && (w_cntNext[i] != '0);
        end
        w_countNext = (w_bundle && (r_count != '1)) ? r_count + COUNT_WIDTH'(1) : r_count;
    end

    // The result is thresholded from the post-update counters so it is ready one cycle after the last item.
    always_ff @(posedge clk_i) begin
        if (w_clear) begin
            r_state  <= S_IDLE;
            r_n      <= CFG_W'(1);
            r_fill   <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_empty  <= 1'b0;
            for (int k = 0; k < HIST_DEPTH; k++) r_hist[k] <= '0;
            for (int i = 0; i < DIM; i++) r_cnt[i] <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < DIM; i++) r_cnt[i] <= w_cntNext[i];
            for (int k = HIST_DEPTH - 1; k > 0; k--) r_hist[k] <= r_hist[k-1];
            r_hist[0] <= bus.item_i;
            r_count   <= w_countNext;
            r_fill    <= w_fillNext;
            if (r_state == S_IDLE) r_n <= w_cfgN;
            if (bus.item_last_i) begin
                r_result <= w_resultNext;
                r_empty  <= (w_countNext == '0);
                r_state  <= S_OUT;
            end else begin
                r_state  <= S_ACCUM;
            end
        end
    end

    assign bus.item_ready_o   = (r_state != S_OUT);
    assign bus.result_valid_o = (r_state == S_OUT);
    assign bus.busy_o         = (r_state != S_IDLE);
    assign bus.result_o       = r_result;
    assign bus.result_count_o = r_count;
    assign bus.result_empty_o = r_empty;
endmodule

// File: tb/tb_hd_ngram_encoder.sv
// Bench for hd_ngram_encoder: directed sequences with literal results plus randomized
// sequences scored against a queue-based N-gram model on every cycle.
module tb_hd_ngram_encoder;
    localparam int DIM         = 8;
    localparam int NGRAM_MAX   = 4;
    localparam int CNTR_WIDTH  = 4;
    localparam int COUNT_WIDTH = 4;
    localparam int CNT_LIM     = 7;
    localparam int COUNT_LIM   = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hd_ngram_encoder_if #(.DIM(DIM), .NGRAM_MAX(NGRAM_MAX), .COUNT_WIDTH(COUNT_WIDTH)) bus();

    hd_ngram_encoder #(
        .DIM(DIM), .NGRAM_MAX(NGRAM_MAX), .CNTR_WIDTH(CNTR_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int readyMode = 0;

    // Reference model: 0 idle, 1 accumulating, 2 result pending.
    int         mState = 0;
    int         mN = 1;
    logic [7:0] mHist[$];
    int         mCnt[DIM];
    int         mCount = 0;
    logic [7:0] mResult = 8'h00;
    logic       mEmpty = 1'b0;
    logic [7:0] mItem;
    logic [7:0] mGram;

    function automatic logic [7:0] rotModel(input logic [7:0] v, input int k);
        logic [15:0] w;
        int s;
        s = k % DIM;
        w = {v, v};
        return w[15 - s -: 8];
    endfunction

    task automatic modelReset();
        mState = 0;
        mN = 1;
        mHist.delete();
        for (int i = 0; i < DIM; i++) mCnt[i] = 0;
        mCount  = 0;
        mResult = 8'h00;
        mEmpty  = 1'b0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            modelReset();
        end else if (mState == 2) begin
            if (bus.result_ready_i) modelReset();
        end else if (bus.item_valid_i) begin
            mItem = bus.item_i;
            if (mState == 0) begin
                mN = int'(bus.cfg_ngram_len_i);
                if (mN < 1) mN = 1;
                if (mN > NGRAM_MAX) mN = NGRAM_MAX;
                mState = 1;
            end
            if (mHist.size() + 1 >= mN) begin
                mGram = mItem;
                for (int k = 1; k < mN; k++) mGram = mGram ^ rotModel(mHist[mHist.size() - k], k);
                for (int i = 0; i < DIM; i++) begin
                    if (mGram[i]) mCnt[i] = (mCnt[i] < CNT_LIM) ? mCnt[i] + 1 : CNT_LIM;
                    else          mCnt[i] = (mCnt[i] > -CNT_LIM) ? mCnt[i] - 1 : -CNT_LIM;
                end
                if (mCount < COUNT_LIM) mCount++;
            end
            mHist.push_back(mItem);
            if (bus.item_last_i) begin
                for (int i = 0; i < DIM; i++) mResult[i] = (mCnt[i] > 0);
                mEmpty = (mCount == 0);
                mState = 2;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("item_ready", 32'(bus.item_ready_o), 32'(mState != 2));
        check("result_valid", 32'(bus.result_valid_o), 32'(mState == 2));
        check("busy", 32'(bus.busy_o), 32'(mState != 0));
        if (mState == 2) begin
            check("result", 32'(bus.result_o), 32'(mResult));
            check("result_count", 32'(bus.result_count_o), 32'(mCount));
            check("result_empty", 32'(bus.result_empty_o), 32'(mEmpty));
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (readyMode == 0)      bus.result_ready_i = 1'b1;
        else if (readyMode == 1) bus.result_ready_i = 1'($urandom_range(0, 1));
        else                     bus.result_ready_i = 1'b0;
    end

    // Called just after a rising edge; returns just after the edge that took the item.
    task automatic applyStimulus(input logic [7:0] item, input logic last);
        int waited;
        bit ok;
        bus.item_valid_i = 1'b1;
        bus.item_i       = item;
        bus.item_last_i  = last;
        waited = 0;
        ok = 1'b0;
        while (!ok && waited <= 50) begin
            @(negedge clk);
            if (mState != 2) ok = 1'b1;
            else waited++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL item_accept_timeout: got none expected handshake within 50 cycles");
        end
        @(posedge clk);
        #1;
        bus.item_valid_i = 1'b0;
        bus.item_last_i  = 1'b0;
    endtask

    task automatic waitIdle();
        int waited;
        waited = 0;
        while (mState != 0 && waited <= 50) begin
            @(negedge clk);
            waited++;
        end
        if (mState != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL idle_timeout: got state %0d expected 0 within 50 cycles", mState);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expRes,
                               input int expCount, input logic expEmpty);
        @(negedge clk);
        check({name, "_valid"}, 32'(bus.result_valid_o), 32'd1);
        check({name, "_result"}, 32'(bus.result_o), 32'(expRes));
        check({name, "_count"}, 32'(bus.result_count_o), 32'(expCount));
        check({name, "_empty"}, 32'(bus.result_empty_o), 32'(expEmpty));
        check({name, "_model_result"}, 32'(mResult), 32'(expRes));
        check({name, "_model_count"}, 32'(mCount), 32'(expCount));
    endtask

    task automatic checkReset(input string name);
        check({name, "_ready"}, 32'(bus.item_ready_o), 32'd1);
        check({name, "_valid"}, 32'(bus.result_valid_o), 32'd0);
        check({name, "_busy"}, 32'(bus.busy_o), 32'd0);
        check({name, "_result"}, 32'(bus.result_o), 32'd0);
        check({name, "_count"}, 32'(bus.result_count_o), 32'd0);
        check({name, "_empty"}, 32'(bus.result_empty_o), 32'd0);
    endtask

    initial begin
        #300000;
        failures++;
        $display("[TB] FAIL watchdog: got no finish expected finish before 300000");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int len;
        logic [7:0] base;
        logic [7:0] item;
        bit aborted;
        bus.cfg_ngram_len_i = '0;
        bus.item_valid_i    = 1'b0;
        bus.item_i          = '0;
        bus.item_last_i     = 1'b0;
        bus.result_ready_i  = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkReset("reset");
        @(posedge clk);
        #1;

        bus.cfg_ngram_len_i = 3'd1;
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h0F, 1'b1);
        checkOutput("n1_basic", 8'hF0, 3, 1'b0);
        waitIdle();

        bus.cfg_ngram_len_i = 3'd2;
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h03, 1'b1);
        checkOutput("n2_bind", 8'h01, 1, 1'b0);
        waitIdle();

        bus.cfg_ngram_len_i = 3'd1;
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'h00, 1'b1);
        checkOutput("tie_zero", 8'h00, 2, 1'b0);
        waitIdle();

        repeat (10) applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'h00, 1'b1);
        checkOutput("cnt_sat", 8'hFF, 11, 1'b0);
        waitIdle();

        bus.cfg_ngram_len_i = 3'd3;
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'h55, 1'b1);
        checkOutput("empty", 8'h00, 0, 1'b1);
        waitIdle();

        bus.cfg_ngram_len_i = 3'd0;
        applyStimulus(8'h81, 1'b1);
        checkOutput("cfg_zero", 8'h81, 1, 1'b0);
        waitIdle();

        // N clamps to 4; the mid-sequence cfg change must be ignored.
        bus.cfg_ngram_len_i = 3'd7;
        applyStimulus(8'h01, 1'b0);
        bus.cfg_ngram_len_i = 3'd1;
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h04, 1'b0);
        applyStimulus(8'h08, 1'b1);
        checkOutput("cfg_clamp", 8'h00, 1, 1'b0);
        waitIdle();

        readyMode = 2;
        bus.cfg_ngram_len_i = 3'd1;
        applyStimulus(8'h3C, 1'b1);
        checkOutput("backpressure", 8'h3C, 1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_result", 32'(bus.result_o), 32'h3C);
            check("hold_count", 32'(bus.result_count_o), 32'd1);
            check("hold_ready", 32'(bus.item_ready_o), 32'd0);
        end
        readyMode = 0;
        waitIdle();

        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'hFF, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkReset("mid_reset");
        @(posedge clk);
        #1;
        applyStimulus(8'h0F, 1'b1);
        checkOutput("after_reset", 8'h0F, 1, 1'b0);
        waitIdle();

        readyMode = 1;
        for (int s = 0; s < 40; s++) begin
            bus.cfg_ngram_len_i = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 20);
            base = 8'($urandom);
            aborted = 1'b0;
            for (int j = 0; j < len && !aborted; j++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                if ($urandom_range(0, 5) == 0) bus.cfg_ngram_len_i = 3'($urandom_range(0, 7));
                item = ($urandom_range(0, 2) == 0) ? 8'($urandom) : base;
                if ((s % 8 == 5) && (j == len / 2) && (j > 0)) begin
                    rst = 1'b1;
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    aborted = 1'b1;
                end else begin
                    applyStimulus(item, (j == len - 1));
                end
            end
            waitIdle();
        end
        readyMode = 0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
